// File: rtl/vn_debias_feeder.sv
// Von Neumann debiaser feeding the TRNG sample shift register, with word framing.
// Optional repetition-count health test enabled by defining VN_RCT_EN.
module vn_debias_feeder #(
  parameter int NBITS      = 32,
  parameter int DISC_W     = 16,
  parameter int RCT_CUTOFF = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              raw_bit,
  input  logic              raw_valid,
  output logic              out_bit,
  output logic              out_en,
  output logic              word_ready,
  input  logic              word_ack,
  output logic [DISC_W-1:0] discard_cnt,
  output logic              health_fail
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {S_FIRST, S_SECOND} state_t;

  state_t            r_state;
  logic              r_first;
  logic [CW-1:0]     r_cnt;
  logic              r_out_bit;
  logic              r_out_en;
  logic              r_word_ready;
  logic [DISC_W-1:0] r_disc;

  logic w_pair_done;
  logic w_differ;
  logic w_emit;
  logic w_hf;

  assign w_pair_done = en && raw_valid && (r_state == S_SECOND);
  assign w_differ    = (raw_bit != r_first);
  // A differing pair is lost while a word is waiting for ack or the source is unhealthy
  assign w_emit      = w_pair_done && w_differ && !r_word_ready && !w_hf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FIRST;
      r_first      <= 1'b0;
      r_cnt        <= '0;
      r_out_bit    <= 1'b0;
      r_out_en     <= 1'b0;
      r_word_ready <= 1'b0;
      r_disc       <= '0;
    end else begin
      r_out_en <= w_emit;
      if (w_emit)
        r_out_bit <= r_first;

      if (!en) begin
        r_state <= S_FIRST;
      end else if (raw_valid) begin
        if (r_state == S_FIRST) begin
          r_first <= raw_bit;
          r_state <= S_SECOND;
        end else begin
          r_state <= S_FIRST;
          if (!w_differ && (r_disc != {DISC_W{1'b1}}))
            r_disc <= r_disc + 1'b1;
        end
      end

      // Ack wins; out_en can never coincide with word_ready because pairs take two samples
      if (r_word_ready && word_ack) begin
        r_word_ready <= 1'b0;
        r_cnt        <= '0;
      end else if (r_out_en) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(NBITS - 1))
          r_word_ready <= 1'b1;
      end
    end
  end

`ifdef VN_RCT_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run_nxt;
  logic          r_last;
  logic          r_hf;

  // Run length of identical raw bits, saturating at the cutoff; 0 means no bit seen yet
  always_comb begin
    w_run_nxt = r_run;
    if (raw_valid) begin
      if ((r_run != '0) && (raw_bit == r_last))
        w_run_nxt = (r_run == RW'(RCT_CUTOFF)) ? r_run : r_run + 1'b1;
      else
        w_run_nxt = RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= '0;
      r_last <= 1'b0;
      r_hf   <= 1'b0;
    end else begin
      r_run <= w_run_nxt;
      if (raw_valid)
        r_last <= raw_bit;
      if (w_run_nxt == RW'(RCT_CUTOFF))
        r_hf <= 1'b1;
    end
  end

  assign w_hf = r_hf;
`else
  // Constant 0: the cutoff only matters when the run test is built in
  assign w_hf = (RCT_CUTOFF < 0);
`endif

  assign out_bit     = r_out_bit;
  assign out_en      = r_out_en;
  assign word_ready  = r_word_ready;
  assign discard_cnt = r_disc;
  assign health_fail = w_hf;

endmodule

// File: tb/tb_vn_debias_feeder.sv
// Self-checking bench for vn_debias_feeder: pair table, scoreboard of emitted bits,
// and hand sequences for framing, idle gaps, enable drop, reset and health test.
module tb_vn_debias_feeder;
  localparam int NB = 4;
  localparam int DW = 2;
  localparam int RC = 32;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, raw_bit, raw_valid, word_ack;
  logic          out_bit, out_en, word_ready, health_fail;
  logic [DW-1:0] discard_cnt;

  vn_debias_feeder #(.NBITS(NB), .DISC_W(DW), .RCT_CUTOFF(RC)) dut (
    .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .out_bit(out_bit), .out_en(out_en), .word_ready(word_ready), .word_ack(word_ack),
    .discard_cnt(discard_cnt), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit q[$];
  int m_cnt;
  bit m_ready;
  bit m_hf;
  int m_disc;

  typedef struct {
    logic b0;
    logic b1;
    logic exp_en;
    int   exp_disc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every observed strobe must match the oldest predicted bit
  always @(negedge clk) begin
    if (rst === 1'b0 && out_en === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_en: got out_en=1 expected no pending bit at %0t", $time);
      end else begin
        bit e;
        e = q.pop_front();
        if (out_bit !== e) begin
          errors++;
          $display("FAIL sb_out_bit: got %0d expected %0d at %0t", out_bit, e, $time);
        end
      end
    end
  end

  task automatic model_emit(input bit b);
    if (!m_ready && !m_hf) begin
      q.push_back(b);
      m_cnt++;
      if (m_cnt == NB) m_ready = 1'b1;
    end
  endtask

  // Drives a back-to-back pair; returns at the negedge where the result is visible
  task automatic pair(input bit b0, input bit b1);
    raw_valid = 1'b1;
    raw_bit   = b0;
    @(negedge clk);
    raw_bit = b1;
    if (b0 == b1) begin
      if (m_disc < DMAX) m_disc++;
    end else begin
      model_emit(b0);
    end
    @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw_valid = 1'b0;
    word_ack = 1'b0;
    @(negedge clk);
    chk("rst_out_bit", {31'd0, out_bit}, 0);
    chk("rst_out_en", {31'd0, out_en}, 0);
    chk("rst_word_ready", {31'd0, word_ready}, 0);
    chk("rst_discard", {30'd0, discard_cnt}, 0);
    chk("rst_health", {31'd0, health_fail}, 0);
    rst = 1'b0;
    q.delete();
    m_cnt = 0; m_ready = 1'b0; m_hf = 1'b0; m_disc = 0;
  endtask

  task automatic ack();
    word_ack = 1'b1;
    @(negedge clk);
    word_ack = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0; word_ack = 1'b0;
    tbl[0] = '{1'b0, 1'b1, 1'b1, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 3};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 3};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 3};   // word full: suppressed
    @(negedge clk);
    do_reset();
    en = 1'b1;

    // T1/T2/T3: table of pairs; 4 emissions fill the word, 5th is dropped
    for (int i = 0; i < 8; i++) begin
      pair(tbl[i].b0, tbl[i].b1);
      chk($sformatf("tbl%0d_out_en", i), {31'd0, out_en}, {31'd0, tbl[i].exp_en});
      chk($sformatf("tbl%0d_discard", i), {30'd0, discard_cnt}, tbl[i].exp_disc);
    end
    chk("word_ready_full", {31'd0, word_ready}, {31'd0, m_ready});
    ack();
    chk("word_ready_after_ack", {31'd0, word_ready}, 0);

    // Ack while not ready must not clear the count
    pair(1'b1, 1'b0);
    pair(1'b0, 1'b1);
    ack();
    pair(1'b1, 1'b0);
    chk("word_ready_3of4", {31'd0, word_ready}, 0);
    pair(1'b0, 1'b1);
    @(negedge clk);
    chk("word_ready_ignored_ack", {31'd0, word_ready}, 1);
    ack();

    // T2 saturation from zero
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pair(i[0], i[0]);
      chk($sformatf("sat%0d_discard", i), {30'd0, discard_cnt}, (i + 1 > DMAX) ? DMAX : i + 1);
    end

    // T4: idle gap inside a pair, then a half pair dropped by en=0
    raw_valid = 1'b1; raw_bit = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
    repeat (3) @(negedge clk);
    raw_valid = 1'b1; raw_bit = 1'b0;
    model_emit(1'b1);
    @(negedge clk);
    raw_valid = 1'b0;
    chk("gap_out_en", {31'd0, out_en}, 1);
    @(negedge clk);
    chk("hold_out_en", {31'd0, out_en}, 0);
    chk("hold_out_bit", {31'd0, out_bit}, 1);
    raw_valid = 1'b1; raw_bit = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    pair(1'b0, 1'b1);
    chk("en_drop_out_en", {31'd0, out_en}, 1);

    // T5: reset mid-pair and mid-word
    raw_valid = 1'b1; raw_bit = 1'b1;
    @(negedge clk);
    do_reset();
    pair(1'b0, 1'b1);
    chk("post_rst_out_en", {31'd0, out_en}, 1);
    @(negedge clk);
    chk("post_rst_single", {31'd0, out_en}, 0);
    chk("post_rst_word_ready", {31'd0, word_ready}, 0);

`ifdef VN_RCT_EN
    // T6: run of RC ones trips the sticky health flag
    do_reset();
    en = 1'b1;
    raw_valid = 1'b1; raw_bit = 1'b1;
    for (int i = 0; i < RC - 1; i++) @(negedge clk);
    chk("hf_before_cutoff", {31'd0, health_fail}, 0);
    @(negedge clk);
    raw_valid = 1'b0;
    chk("hf_at_cutoff", {31'd0, health_fail}, 1);
    m_hf = 1'b1;
    pair(1'b0, 1'b1);
    chk("hf_suppress", {31'd0, out_en}, 0);
    chk("hf_sticky", {31'd0, health_fail}, 1);
    do_reset();
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
